uart_rx: RTL and testbench

//  Serial receive half of the APB UART; pairs with the UART transmitter using the same cfg_* encoding.

---
 rtl/uart_rx.sv | 196 +++++++++++++++++++
 tb/tb_uart_rx.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: synchronises rx_i, qualifies the start bit, samples mid-bit,
// and hands each 5-8 bit character to a one-entry valid/ready output register.
module uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_i,
  output logic        busy_o,
  input  logic        cfg_en_i,
  input  logic [15:0] cfg_div_i,
  input  logic        cfg_parity_en_i,
  input  logic [1:0]  cfg_parity_sel_i,
  input  logic [1:0]  cfg_bits_i,
  input  logic        cfg_stop_bits_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        err_parity_o,
  output logic        err_frame_o,
  output logic        err_overrun_o,
  input  logic        err_clr_i,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP1  = 3'd4,
    S_STOP2  = 3'd5
  } state_t;

  state_t            state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic              rs;
  logic              rs_q;
  logic              fall;
  logic [15:0]       cnt;
  logic [2:0]        bit_cnt;
  logic [2:0]        last_bit;
  logic [7:0]        data_q;
  logic              acc_q;
  logic              perr_q;
  logic              ferr_q;
  logic              done_q;
  logic              exp_par;
  logic              mid_tick;
  logic              bit_tick;
  logic              load;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
  end

  assign rs       = sync_q[SYNC_STAGES-1];
  assign fall     = rs_q & ~rs;
  assign mid_tick = (cnt == (cfg_div_i >> 1));
  assign bit_tick = (cnt == cfg_div_i);
  // Index of the final data bit: 8 bits -> 7, 7 -> 6, 6 -> 5, 5 -> 4.
  assign last_bit = ~{1'b0, cfg_bits_i};

  always_comb begin
    exp_par = 1'b0;
    case (cfg_parity_sel_i)
      2'b00: exp_par = ~acc_q;
      2'b01: exp_par = acc_q;
      2'b10: exp_par = 1'b0;
      2'b11: exp_par = 1'b1;
      default: exp_par = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      data_q  <= '0;
      acc_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      done_q  <= 1'b0;
      rs_q    <= 1'b1;
    end else begin
      rs_q   <= rs;
      done_q <= 1'b0;
      if (!cfg_en_i) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            cnt <= '0;
            if (fall) state <= S_START;
          end
          S_START: begin
            if (mid_tick) begin
              cnt <= '0;
              if (!rs) begin
                state   <= S_DATA;
                bit_cnt <= '0;
                data_q  <= '0;
                acc_q   <= 1'b0;
                perr_q  <= 1'b0;
                ferr_q  <= 1'b0;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          S_DATA: begin
            if (bit_tick) begin
              cnt             <= '0;
              data_q[bit_cnt] <= rs;
              acc_q           <= acc_q ^ rs;
              bit_cnt         <= bit_cnt + 3'd1;
              if (bit_cnt == last_bit) state <= cfg_parity_en_i ? S_PARITY : S_STOP1;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          S_PARITY: begin
            if (bit_tick) begin
              cnt    <= '0;
              perr_q <= (rs != exp_par);
              state  <= S_STOP1;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          S_STOP1: begin
            if (bit_tick) begin
              cnt <= '0;
              if (!rs) ferr_q <= 1'b1;
              if (cfg_stop_bits_i) begin
                state <= S_STOP2;
              end else begin
                state  <= S_IDLE;
                done_q <= 1'b1;
              end
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          S_STOP2: begin
            if (bit_tick) begin
              cnt    <= '0;
              if (!rs) ferr_q <= 1'b1;
              state  <= S_IDLE;
              done_q <= 1'b1;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          default: begin
            state <= S_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  // Handshake: a byte transfers on any cycle with rx_valid_o & rx_ready_i; until
  // then rx_data_o is held. A completing frame may refill the register in that same cycle.
  assign load = done_q & (~rx_valid_o | rx_ready_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_data_o     <= '0;
      rx_valid_o    <= 1'b0;
      err_parity_o  <= 1'b0;
      err_frame_o   <= 1'b0;
      err_overrun_o <= 1'b0;
    end else begin
      if (load) begin
        rx_data_o  <= data_q;
        rx_valid_o <= 1'b1;
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
      err_parity_o  <= err_clr_i ? 1'b0 : (err_parity_o  | (load & perr_q));
      err_frame_o   <= err_clr_i ? 1'b0 : (err_frame_o   | (load & ferr_q));
      err_overrun_o <= err_clr_i ? 1'b0 : (err_overrun_o | (done_q & ~load));
    end
  end

  assign busy_o      = (state != S_IDLE);
  assign dbg_state_o = state;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus randomized frames, checked against
// a frame-level model (masked data, parity by bit count, stop-bit levels).
module tb_uart_rx;

  logic        clk;
  logic        rst;
  logic        rx;
  logic        busy;
  logic        cfg_en;
  logic [15:0] cfg_div;
  logic        cfg_par_en;
  logic [1:0]  cfg_par_sel;
  logic [1:0]  cfg_bits;
  logic        cfg_stop;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        err_par;
  logic        err_frm;
  logic        err_ovr;
  logic        err_clr;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic       exp_perr, exp_ferr, exp_ovr;

  uart_rx #(.SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst), .rx_i(rx), .busy_o(busy),
    .cfg_en_i(cfg_en), .cfg_div_i(cfg_div), .cfg_parity_en_i(cfg_par_en),
    .cfg_parity_sel_i(cfg_par_sel), .cfg_bits_i(cfg_bits), .cfg_stop_bits_i(cfg_stop),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
    .err_parity_o(err_par), .err_frame_o(err_frm), .err_overrun_o(err_ovr),
    .err_clr_i(err_clr), .dbg_state_o(dbg_state)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (int'(cfg_div) + 1) tick();
  endtask

  // bad_stop: 0 none, 1 first stop bit low, 2 second stop bit low
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input int bad_stop,
                            input int gap_bits, input bit accept);
    int         nb;
    int         ones;
    logic [7:0] dm;
    logic       pb;
    nb   = 8 - int'(cfg_bits);
    dm   = d & (8'hFF >> (8 - nb));
    ones = $countones(dm);
    case (cfg_par_sel)
      2'b00:   pb = ((ones % 2) == 0);
      2'b01:   pb = ((ones % 2) == 1);
      2'b10:   pb = 1'b0;
      default: pb = 1'b1;
    endcase
    pb = pb ^ bad_par;
    if (accept) exp_q.push_back(dm);
    send_bit(1'b0);
    for (int i = 0; i < nb; i++) send_bit(dm[i]);
    if (cfg_par_en) send_bit(pb);
    send_bit(bad_stop != 1);
    if (cfg_stop) send_bit(bad_stop != 2);
    for (int i = 0; i < gap_bits; i++) send_bit(1'b1);
    if (accept) begin
      exp_perr = exp_perr | (cfg_par_en & bad_par);
      exp_ferr = exp_ferr | (bad_stop == 1) | (cfg_stop & (bad_stop == 2));
    end else begin
      exp_ovr = 1'b1;
    end
  endtask

  task automatic check_errs(input string tag);
    repeat (6) tick();
    check_eq({tag, "_err_parity"},  err_par, exp_perr);
    check_eq({tag, "_err_frame"},   err_frm, exp_ferr);
    check_eq({tag, "_err_overrun"}, err_ovr, exp_ovr);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    exp_perr = 1'b0; exp_ferr = 1'b0; exp_ovr = 1'b0;
    check_eq({tag, "_errs_cleared"}, {err_par, err_frm, err_ovr}, 3'b000);
  endtask

  // Scoreboard: every accepted handshake must deliver the oldest expected byte
  always @(negedge clk) begin
    if (!rst && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) check_eq("rx_unexpected_byte_q_size", exp_q.size(), 1);
      else                   check_eq("rx_data", rx_data, exp_q.pop_front());
    end
  end

  initial begin
    int t;
    int seen;
    rst = 1'b1; rx = 1'b1; cfg_en = 1'b1; cfg_div = 16'd9;
    cfg_par_en = 1'b0; cfg_par_sel = 2'b00; cfg_bits = 2'b00; cfg_stop = 1'b0;
    rx_ready = 1'b1; err_clr = 1'b0;
    exp_perr = 1'b0; exp_ferr = 1'b0; exp_ovr = 1'b0;
    repeat (3) tick();
    check_eq("reset_valid", rx_valid, 0);
    check_eq("reset_data", rx_data, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_errs", {err_par, err_frm, err_ovr}, 0);
    check_eq("reset_state", dbg_state, 0);
    rst = 1'b0;
    repeat (3) tick();

    // 8N1 0xA5 held until ready
    rx_ready = 1'b0;
    send_frame(8'hA5, 0, 0, 1, 1);
    repeat (4) tick();
    check_eq("a5_valid", rx_valid, 1);
    check_eq("a5_data", rx_data, 8'hA5);
    repeat (5) tick();
    check_eq("a5_valid_held", rx_valid, 1);
    rx_ready = 1'b1;
    tick();
    check_eq("a5_valid_cleared", rx_valid, 0);
    check_errs("a5");

    // 7E1 0x55 with wrong parity
    cfg_bits = 2'b01; cfg_par_en = 1'b1; cfg_par_sel = 2'b01;
    send_frame(8'h55, 1, 0, 1, 1);
    check_errs("par");

    // Start-bit glitch rejected
    cfg_bits = 2'b00; cfg_par_en = 1'b0;
    rx = 1'b0;
    repeat (3) tick();
    rx = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) seen = 1;
      tick();
    end
    check_eq("glitch_busy_seen", seen, 1);
    check_eq("glitch_busy_dropped", busy, 0);
    check_eq("glitch_no_valid", rx_valid, 0);
    check_eq("glitch_state_idle", dbg_state, 0);

    // Overrun, then refill in the handshake cycle
    rx_ready = 1'b0;
    send_frame(8'h11, 0, 0, 1, 1);
    send_frame(8'h22, 0, 0, 1, 0);
    repeat (4) tick();
    check_eq("ovr_data_kept", rx_data, 8'h11);
    check_errs("ovr");
    fork
      send_frame(8'h22, 0, 0, 1, 1);
      begin
        t = 0;
        while (!busy && t < 3000) begin tick(); t++; end
        while (busy && t < 3000) begin tick(); t++; end
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check_eq("refill_in_time", t < 3000, 1);
      end
    join
    repeat (4) tick();
    check_eq("refill_data", rx_data, 8'h22);
    check_eq("refill_valid", rx_valid, 1);
    check_errs("refill");
    rx_ready = 1'b1;
    repeat (3) tick();

    // Two stop bits with bad second stop; then 5N1
    cfg_stop = 1'b1;
    send_frame(8'h3C, 0, 2, 1, 1);
    check_errs("stop2");
    cfg_stop = 1'b0; cfg_bits = 2'b11;
    send_frame(8'h1F, 0, 0, 1, 1);
    check_errs("5n1");
    cfg_bits = 2'b00;

    // Reset mid-frame
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    check_eq("rst_mid_busy", busy, 1);
    rst = 1'b1;
    exp_q.delete();
    tick();
    check_eq("rst_mid_idle", busy, 0);
    check_eq("rst_mid_valid", rx_valid, 0);
    rx = 1'b1;
    tick();
    rst = 1'b0;
    repeat (20) tick();

    // Enable drop mid-frame keeps the pending byte
    rx_ready = 1'b0;
    send_frame(8'h5A, 0, 0, 1, 1);
    send_bit(1'b0); send_bit(1'b1);
    check_eq("en_mid_busy", busy, 1);
    cfg_en = 1'b0;
    tick(); tick();
    check_eq("en_drop_idle", busy, 0);
    check_eq("en_drop_valid_kept", rx_valid, 1);
    check_eq("en_drop_data_kept", rx_data, 8'h5A);
    rx = 1'b1;
    repeat (20) tick();
    cfg_en = 1'b1;
    rx_ready = 1'b1;
    repeat (3) tick();
    send_frame(8'hC3, 0, 0, 0, 1);
    send_frame(8'hC3, 0, 0, 1, 1);
    check_errs("b2b");

    // Randomized frames and configurations
    for (int n = 0; n < 20; n++) begin
      int bs;
      cfg_div     = 16'($urandom_range(3, 12));
      cfg_bits    = 2'($urandom_range(0, 3));
      cfg_par_en  = 1'($urandom_range(0, 1));
      cfg_par_sel = 2'($urandom_range(0, 3));
      cfg_stop    = 1'($urandom_range(0, 1));
      bs = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, cfg_stop ? 2 : 1)) : 0;
      send_frame(8'($urandom), cfg_par_en && ($urandom_range(0, 3) == 0), bs, 1, 1);
      check_errs("rand");
    end

    repeat (5) tick();
    check_eq("exp_q_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
